// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: PC inputs, redirect/hazard controls, imem request and IF/ID latch outputs.
interface fetch_stage_if;
    logic [31:0] PC;
    logic [31:0] npc;
    logic        ihit;
    logic [31:0] iload;
    logic        brtaken;
    logic [31:0] brtarget;
    logic        jump;
    logic [31:0] jtarget;
    logic        stall;
    logic        iREN;
    logic [31:0] iaddr;
    logic        pcEN;
    logic [31:0] newpc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;

    modport slave (
        input  PC, npc, ihit, iload, brtaken, brtarget, jump, jtarget, stall,
        output iREN, iaddr, pcEN, newpc, ifid_instr, ifid_npc, ifid_valid
    );

    modport master (
        output PC, npc, ihit, iload, brtaken, brtarget, jump, jtarget, stall,
        input  iREN, iaddr, pcEN, newpc, ifid_instr, ifid_npc, ifid_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: imem request, redirect tracking and IF/ID latch.
// Optional performance counters enabled by macro FETCH_STAGE_CNT_EN.
//
// state | meaning
// FETCH | read request outstanding, waiting for ihit
// HOLD  | fetched word buffered while IF/ID is stalled, no request
module fetch_stage #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    fetch_stage_if.slave     fif
`ifdef FETCH_STAGE_CNT_EN
    ,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state, nxt_state;
    logic        pend, nxt_pend;
    logic [31:0] pend_target, nxt_pend_target;
    logic [31:0] hold_instr, hold_npc;
    logic [31:0] instr_q, npc_q;
    logic        valid_q;

    logic        redir;
    logic [31:0] redir_tgt;
    logic        pc_en;
    logic [31:0] new_pc;
    logic        ld_word, ld_held, ld_bubble, ld_hold;

    always_comb begin
        redir           = fif.brtaken | fif.jump;
        redir_tgt       = fif.brtaken ? fif.brtarget : fif.jtarget;
        pc_en           = 1'b0;
        new_pc          = fif.npc;
        nxt_state       = state;
        nxt_pend        = pend;
        nxt_pend_target = pend_target;
        ld_word         = 1'b0;
        ld_held         = 1'b0;
        ld_bubble       = 1'b0;
        ld_hold         = 1'b0;
        case (state)
            FETCH: begin
                if (!fif.ihit) begin
                    if (redir) begin
                        nxt_pend        = 1'b1;
                        nxt_pend_target = redir_tgt;
                    end
                end else if (redir || pend) begin
                    // the returning word belongs to the wrong path
                    pc_en     = 1'b1;
                    new_pc    = redir ? redir_tgt : pend_target;
                    nxt_pend  = 1'b0;
                    ld_bubble = ~fif.stall;
                end else if (!fif.stall) begin
                    pc_en   = 1'b1;
                    ld_word = 1'b1;
                end else begin
                    ld_hold   = 1'b1;
                    nxt_state = HOLD;
                end
            end
            default: begin
                if (redir) begin
                    pc_en     = 1'b1;
                    new_pc    = redir_tgt;
                    ld_bubble = ~fif.stall;
                    nxt_state = FETCH;
                end else if (!fif.stall) begin
                    pc_en     = 1'b1;
                    new_pc    = hold_npc;
                    ld_held   = 1'b1;
                    nxt_state = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FETCH;
            pend        <= 1'b0;
            pend_target <= '0;
            hold_instr  <= '0;
            hold_npc    <= '0;
            instr_q     <= '0;
            npc_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state       <= nxt_state;
            pend        <= nxt_pend;
            pend_target <= nxt_pend_target;
            if (ld_hold) begin
                hold_instr <= fif.iload;
                hold_npc   <= fif.npc;
            end
            if (ld_word) begin
                instr_q <= fif.iload;
                npc_q   <= fif.npc;
                valid_q <= 1'b1;
            end else if (ld_held) begin
                instr_q <= hold_instr;
                npc_q   <= hold_npc;
                valid_q <= 1'b1;
            end else if (ld_bubble) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef FETCH_STAGE_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (ld_word || ld_held)
                fetch_cnt <= fetch_cnt + 1'b1;
            if (state == HOLD || !fif.ihit)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    // outputs are gated while reset is held so nothing leaks to the PC or imem
    assign fif.iREN       = (state == FETCH) & ~RST;
    assign fif.iaddr      = fif.PC;
    assign fif.pcEN       = pc_en & ~RST;
    assign fif.newpc      = fif.pcEN ? new_pc : fif.npc;
    assign fif.ifid_instr = instr_q;
    assign fif.ifid_npc   = npc_q;
    assign fif.ifid_valid = valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, reset/counter sequences, random vs model.
module tb_fetch_stage;
    localparam int TB_CNT_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        ihit;
        logic [31:0] iload;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jt;
        logic        stall;
    } in_t;

    typedef struct packed {
        in_t         in;
        logic        e_iren;
        logic        e_pcen;
        logic [31:0] e_newpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } word_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    fetch_stage_if fif ();
`ifdef FETCH_STAGE_CNT_EN
    logic [TB_CNT_W-1:0] fetch_cnt, stall_cnt;
`endif

    fetch_stage #(.CNT_W(TB_CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .fif (fif)
`ifdef FETCH_STAGE_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // reference model: buffered word and pending redirect as small queues
    word_t       held[$];
    logic [31:0] pend_q[$];
    logic [31:0] m_instr, m_npc;
    logic        m_valid;
    int unsigned m_fetches, m_stalls;
    logic        e_iren, e_pcen;
    logic [31:0] e_newpc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        held.delete();
        pend_q.delete();
        m_instr   = '0;
        m_npc     = '0;
        m_valid   = 1'b0;
        m_fetches = 0;
        m_stalls  = 0;
    endtask

    task automatic model_step(input in_t v);
        logic        redir;
        logic [31:0] tgt;
        redir   = v.br | v.jmp;
        tgt     = v.br ? v.brt : v.jt;
        e_pcen  = 1'b0;
        e_newpc = v.npc;
        if (held.size() == 0) begin
            e_iren = 1'b1;
            if (!v.ihit) begin
                m_stalls++;
                if (redir) begin
                    pend_q.delete();
                    pend_q.push_back(tgt);
                end
            end else if (redir || pend_q.size() != 0) begin
                e_pcen  = 1'b1;
                e_newpc = redir ? tgt : pend_q[0];
                pend_q.delete();
                if (!v.stall) m_valid = 1'b0;
            end else if (!v.stall) begin
                e_pcen  = 1'b1;
                m_instr = v.iload;
                m_npc   = v.npc;
                m_valid = 1'b1;
                m_fetches++;
            end else begin
                held.push_back('{instr: v.iload, npc: v.npc});
            end
        end else begin
            e_iren = 1'b0;
            m_stalls++;
            if (redir) begin
                e_pcen  = 1'b1;
                e_newpc = tgt;
                held.delete();
                if (!v.stall) m_valid = 1'b0;
            end else if (!v.stall) begin
                e_pcen  = 1'b1;
                e_newpc = held[0].npc;
                m_instr = held[0].instr;
                m_npc   = held[0].npc;
                m_valid = 1'b1;
                m_fetches++;
                held.delete();
            end
        end
    endtask

    task automatic drive(input in_t v);
        fif.PC       = v.pc;
        fif.npc      = v.npc;
        fif.ihit     = v.ihit;
        fif.iload    = v.iload;
        fif.brtaken  = v.br;
        fif.brtarget = v.brt;
        fif.jump     = v.jmp;
        fif.jtarget  = v.jt;
        fif.stall    = v.stall;
    endtask

    // one clock cycle from a negedge: drive, check combinational outputs, clock, check latch
    task automatic run_cycle(input in_t v, input bit use_tbl, input vec_t ex);
        drive(v);
        model_step(v);
        #1;
        if (use_tbl) begin
            chk("iREN", 32'(fif.iREN), 32'(ex.e_iren));
            if (ex.e_iren) chk("iaddr", fif.iaddr, v.pc);
            chk("pcEN", 32'(fif.pcEN), 32'(ex.e_pcen));
            chk("newpc", fif.newpc, ex.e_newpc);
        end else begin
            chk("iREN", 32'(fif.iREN), 32'(e_iren));
            if (e_iren) chk("iaddr", fif.iaddr, v.pc);
            chk("pcEN", 32'(fif.pcEN), 32'(e_pcen));
            chk("newpc", fif.newpc, e_newpc);
        end
        @(posedge CLK);
        #1;
        if (use_tbl) begin
            chk("ifid_valid", 32'(fif.ifid_valid), 32'(ex.e_valid));
            if (ex.e_valid) begin
                chk("ifid_instr", fif.ifid_instr, ex.e_instr);
                chk("ifid_npc", fif.ifid_npc, ex.e_npc);
            end
        end else begin
            chk("ifid_valid", 32'(fif.ifid_valid), 32'(m_valid));
            if (m_valid) begin
                chk("ifid_instr", fif.ifid_instr, m_instr);
                chk("ifid_npc", fif.ifid_npc, m_npc);
            end
        end
`ifdef FETCH_STAGE_CNT_EN
        chk("fetch_cnt", 32'(fetch_cnt), m_fetches % (1 << TB_CNT_W));
        chk("stall_cnt", 32'(stall_cnt), m_stalls % (1 << TB_CNT_W));
`endif
        @(negedge CLK);
    endtask

    function automatic in_t mk_in(input logic [31:0] pc, input logic ihit, input logic [31:0] iload,
                                  input logic br, input logic [31:0] brt,
                                  input logic jmp, input logic [31:0] jt, input logic stall);
        in_t r;
        r.pc = pc; r.npc = pc + 32'd4; r.ihit = ihit; r.iload = iload;
        r.br = br; r.brt = brt; r.jmp = jmp; r.jt = jt; r.stall = stall;
        return r;
    endfunction

    function automatic vec_t mk_vec(input in_t i, input logic iren, input logic pcen,
                                    input logic [31:0] newpc, input logic valid,
                                    input logic [31:0] instr, input logic [31:0] npc);
        vec_t r;
        r.in = i; r.e_iren = iren; r.e_pcen = pcen; r.e_newpc = newpc;
        r.e_valid = valid; r.e_instr = instr; r.e_npc = npc;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        model_reset();
        RST = 1'b0;
    endtask

    vec_t tbl[18];
    vec_t nullv;
    in_t  iv;

    initial begin
        nullv = '0;
        drive('0);
        model_reset();

        tbl[0]  = mk_vec(mk_in(32'h000, 1, 32'h24010001, 0, 0, 0, 0, 0), 1, 1, 32'h004, 1, 32'h24010001, 32'h004);
        tbl[1]  = mk_vec(mk_in(32'h004, 1, 32'h11111111, 0, 0, 0, 0, 1), 1, 0, 32'h008, 1, 32'h24010001, 32'h004);
        tbl[2]  = mk_vec(mk_in(32'h004, 0, 32'h0,        0, 0, 0, 0, 1), 0, 0, 32'h008, 1, 32'h24010001, 32'h004);
        tbl[3]  = mk_vec(mk_in(32'h004, 0, 32'h0,        0, 0, 0, 0, 1), 0, 0, 32'h008, 1, 32'h24010001, 32'h004);
        tbl[4]  = mk_vec(mk_in(32'h004, 0, 32'h0,        0, 0, 0, 0, 0), 0, 1, 32'h008, 1, 32'h11111111, 32'h008);
        tbl[5]  = mk_vec(mk_in(32'h008, 0, 32'h0,        1, 32'h100, 0, 0, 0), 1, 0, 32'h00C, 1, 32'h11111111, 32'h008);
        tbl[6]  = mk_vec(mk_in(32'h008, 0, 32'h0,        0, 0, 0, 0, 0), 1, 0, 32'h00C, 1, 32'h11111111, 32'h008);
        tbl[7]  = mk_vec(mk_in(32'h008, 1, 32'h22222222, 0, 0, 0, 0, 0), 1, 1, 32'h100, 0, 32'h0, 32'h0);
        tbl[8]  = mk_vec(mk_in(32'h100, 1, 32'h33333333, 1, 32'h200, 1, 32'h300, 0), 1, 1, 32'h200, 0, 32'h0, 32'h0);
        tbl[9]  = mk_vec(mk_in(32'h200, 1, 32'h44444444, 0, 0, 1, 32'h300, 0), 1, 1, 32'h300, 0, 32'h0, 32'h0);
        tbl[10] = mk_vec(mk_in(32'h300, 1, 32'h55555555, 0, 0, 0, 0, 0), 1, 1, 32'h304, 1, 32'h55555555, 32'h304);
        tbl[11] = mk_vec(mk_in(32'h304, 1, 32'h66666666, 0, 0, 0, 0, 1), 1, 0, 32'h308, 1, 32'h55555555, 32'h304);
        tbl[12] = mk_vec(mk_in(32'h304, 0, 32'h0,        0, 0, 1, 32'h400, 1), 0, 1, 32'h400, 1, 32'h55555555, 32'h304);
        tbl[13] = mk_vec(mk_in(32'h400, 0, 32'h0,        0, 0, 0, 0, 0), 1, 0, 32'h404, 1, 32'h55555555, 32'h304);
        tbl[14] = mk_vec(mk_in(32'h400, 1, 32'h77777777, 0, 0, 0, 0, 1), 1, 0, 32'h404, 1, 32'h55555555, 32'h304);
        tbl[15] = mk_vec(mk_in(32'h400, 0, 32'h0,        1, 32'h500, 0, 0, 0), 0, 1, 32'h500, 0, 32'h0, 32'h0);
        tbl[16] = mk_vec(mk_in(32'h500, 1, 32'h99999999, 0, 0, 1, 32'h600, 1), 1, 1, 32'h600, 0, 32'h0, 32'h0);
        tbl[17] = mk_vec(mk_in(32'h600, 1, 32'h88888888, 0, 0, 0, 0, 0), 1, 1, 32'h604, 1, 32'h88888888, 32'h604);

        // reset state with ihit and a redirect asserted must be ignored
        iv = mk_in(32'h40, 1, 32'hDEADBEEF, 1, 32'h900, 0, 0, 0);
        drive(iv);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_iREN", 32'(fif.iREN), 32'h0);
        chk("rst_pcEN", 32'(fif.pcEN), 32'h0);
        chk("rst_valid", 32'(fif.ifid_valid), 32'h0);
        chk("rst_instr", fif.ifid_instr, 32'h0);
        chk("rst_npc", fif.ifid_npc, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        foreach (tbl[i]) run_cycle(tbl[i].in, 1'b1, tbl[i]);

        // reset asserted mid-HOLD acts immediately
        run_cycle(mk_in(32'h700, 1, 32'hABCD0001, 0, 0, 0, 0, 1), 1'b0, nullv);
        #2;
        drive(mk_in(32'h700, 1, 32'hABCD0002, 1, 32'h800, 0, 0, 0));
        RST = 1'b1;
        #1;
        chk("midrst_valid", 32'(fif.ifid_valid), 32'h0);
        chk("midrst_iREN", 32'(fif.iREN), 32'h0);
        chk("midrst_pcEN", 32'(fif.pcEN), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        iv = mk_in(32'h700, 0, 32'h0, 0, 0, 0, 0, 0);
        drive(iv);
        #1;
        chk("post_rst_iREN", 32'(fif.iREN), 32'h1);
        chk("post_rst_iaddr", fif.iaddr, 32'h700);
        @(negedge CLK);

        // counter wrap: 17 fetches then 2 waits
        do_reset();
        for (int i = 0; i < 17; i++)
            run_cycle(mk_in(32'(i * 4), 1, 32'(i), 0, 0, 0, 0, 0), 1'b0, nullv);
`ifdef FETCH_STAGE_CNT_EN
        chk("fetch_cnt_wrap", 32'(fetch_cnt), 32'd1);
`endif
        for (int i = 0; i < 2; i++)
            run_cycle(mk_in(32'h44, 0, 32'h0, 0, 0, 0, 0, 0), 1'b0, nullv);
`ifdef FETCH_STAGE_CNT_EN
        chk("stall_cnt_two", 32'(stall_cnt), 32'd2);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            iv.pc    = $urandom & 32'hFFFF_FFFC;
            iv.npc   = iv.pc + 32'd4;
            iv.ihit  = ($urandom_range(0, 9) < 6);
            iv.iload = $urandom;
            iv.br    = ($urandom_range(0, 9) < 1);
            iv.brt   = $urandom & 32'hFFFF_FFFC;
            iv.jmp   = ($urandom_range(0, 9) < 1);
            iv.jt    = $urandom & 32'hFFFF_FFFC;
            iv.stall = ($urandom_range(0, 9) < 3);
            run_cycle(iv, 1'b0, nullv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port PC  input  32  current fetch address from the program counter.
REQ-005 SHALL have port npc  input  32  PC+4 from the program counter.
REQ-006 SHALL have port ihit  input  1  instruction memory response valid this cycle.
REQ-007 SHALL have port iload  input  32  instruction data, valid when ihit=1.
REQ-008 SHALL have port brtaken, brtarget  input  1/32  EX-stage taken-branch pulse and its target.
REQ-009 SHALL have port jump, jtarget  input  1/32  ID-stage jump pulse and its target.
REQ-010 SHALL have port stall  input  1  hazard unit holds the IF/ID latch.
REQ-011 SHALL have port iREN, iaddr  output  1/32  instruction read request and address.
REQ-012 SHALL have port pcEN, newpc  output  1/32  program counter write enable and next value.
REQ-013 SHALL have port ifid_instr, ifid_npc, ifid_valid  output  32/32/1  IF/ID latch contents.

Function
REQ-014 SHALL implement two states: FETCH (request outstanding) and HOLD (fetched word buffered, no request).
REQ-015 SHALL in FETCH drive iREN=1, iaddr=PC; in HOLD drive iREN=0.
REQ-016 SHALL form a redirect when brtaken|jump; brtaken has priority; target = brtarget else jtarget.
REQ-017 SHALL in FETCH with redirect or pend set but ihit=0 latch the target into pend_target, set pend; a newer redirect overwrites pend_target; pcEN=0.
REQ-018 SHALL in FETCH on ihit with redirect (current or pending): pcEN=1, newpc=current redirect target if present else pend_target, clear pend, discard iload; IF/ID loads ifid_valid=0 unless stall=1 (latch held); remain FETCH.
REQ-019 SHALL in FETCH on ihit with no redirect and stall=0: pcEN=1, newpc=npc, IF/ID <= {iload, npc, 1} next edge.
REQ-020 SHALL in FETCH on ihit with no redirect and stall=1: pcEN=0, buffer {iload, npc} in hold regs, go HOLD; IF/ID unchanged.
REQ-021 SHALL in HOLD with stall=0 and no redirect: IF/ID <= hold regs with valid=1, pcEN=1, newpc=held npc, go FETCH.
REQ-022 SHALL in HOLD on redirect: pcEN=1, newpc=target immediately, discard hold regs, go FETCH; IF/ID <= valid=0 if stall=0, else unchanged.
REQ-023 SHALL keep pcEN=0 in every case not listed; newpc value is don't-care when pcEN=0 but SHALL equal npc.
REQ-024 SHALL never issue more than one pcEN per ihit in FETCH; one-cycle latency from ihit to IF/ID update.

Reset
REQ-025 SHALL on RST=1 asynchronously set state=FETCH, pend=0, pend_target=0, hold regs=0, ifid_instr=0, ifid_npc=0, ifid_valid=0, counters=0.
REQ-026 SHALL, with RST asserted, drive pcEN=0 and iREN=0; a redirect or ihit during reset is ignored.
REQ-027 SHALL resume with iREN=1 on the first cycle after RST deasserts.

Configuration
REQ-028 SHALL, when macro FETCH_STAGE_CNT_EN is defined, add outputs fetch_cnt and stall_cnt (CNT_W each, wrapping modulo 2^CNT_W).
REQ-029 SHALL increment fetch_cnt on each edge IF/ID loads ifid_valid=1; increment stall_cnt on each cycle in HOLD or in FETCH with ihit=0.
REQ-030 SHALL, without FETCH_STAGE_CNT_EN, omit both ports and counter logic; all other behaviour identical.

Verification
REQ-031 Reset then PC=0x0, ihit=1 iload=0x24010001 npc=0x4 -> pcEN=1 newpc=0x4; next edge ifid_instr=0x24010001 ifid_npc=0x4 valid=1.
REQ-032 ihit=1 with stall=1 for 3 cycles, then stall=0 -> iREN=0 and IF/ID unchanged during stall; IF/ID loads buffered word on release, pcEN=1 once.
REQ-033 brtaken=1 brtarget=0x100 while ihit=0, ihit two cycles later -> pcEN=0 until ihit; then pcEN=1 newpc=0x100, ifid_valid=0.
REQ-034 brtaken (0x200) and jump (0x300) same cycle as ihit -> newpc=0x200, iload discarded.
REQ-035 RST asserted mid-HOLD -> immediate ifid_valid=0, iREN=0; after release state FETCH, iREN=1 iaddr=PC.
REQ-036 With FETCH_STAGE_CNT_EN and CNT_W=4: 17 consecutive valid fetches -> fetch_cnt=1 (wrap); 2 wait cycles -> stall_cnt=2.
